// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - opcode constants (instr[15:11])
//   - RegDst / immediate-select / ALU-op enums
//   - ctrl_t: control word produced by decode_ctrl and carried into ID/EX
//   - state_e: decode FSM states
package decode_pkg;

  localparam logic [4:0] OpHalt = 5'h00;
  localparam logic [4:0] OpAdd  = 5'h01;
  localparam logic [4:0] OpSub  = 5'h02;
  localparam logic [4:0] OpAnd  = 5'h03;
  localparam logic [4:0] OpOr   = 5'h04;
  localparam logic [4:0] OpAddi = 5'h05;
  localparam logic [4:0] OpLi   = 5'h06;
  localparam logic [4:0] OpLd   = 5'h08;
  localparam logic [4:0] OpSt   = 5'h09;
  localparam logic [4:0] OpBeq  = 5'h0A;
  localparam logic [4:0] OpJal  = 5'h0C;
  localparam logic [4:0] OpJmp  = 5'h0D;

  // Destination register select; Link targets the top register (NREG-1).
  typedef enum logic [1:0] {
    RegDstRd,
    RegDstRt,
    RegDstRs,
    RegDstLink
  } regdst_e;

  // Immediate source field: instr[4:0], instr[7:0] or instr[10:0].
  typedef enum logic [1:0] {
    Imm5,
    Imm8,
    Imm11
  } immsel_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluPassImm,
    AluCmp
  } alu_e;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  typedef struct packed {
    logic    regwr;
    logic    memen;
    logic    memwr;
    regdst_e regdst;
    immsel_e immsel;
    logic    imm_sext;
    alu_e    alu_op;
    logic    is_branch;
    logic    is_jump;
    logic    is_halt;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: purely combinational opcode -> control-word table.
// Ports:
//   opcode_i  instr[15:11]
//   ctrl_o    decoded control word (unknown opcodes decode as a NOP)
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [4:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.regdst = RegDstRd;
    ctrl_o.immsel = Imm5;
    ctrl_o.alu_op = AluAdd;
    case (opcode_i)
      OpHalt: ctrl_o.is_halt = 1'b1;
      OpAdd:  ctrl_o.regwr = 1'b1;
      OpSub: begin
        ctrl_o.regwr  = 1'b1;
        ctrl_o.alu_op = AluSub;
      end
      OpAnd: begin
        ctrl_o.regwr  = 1'b1;
        ctrl_o.alu_op = AluAnd;
      end
      OpOr: begin
        ctrl_o.regwr  = 1'b1;
        ctrl_o.alu_op = AluOr;
      end
      OpAddi: begin
        ctrl_o.regwr    = 1'b1;
        ctrl_o.regdst   = RegDstRt;
        ctrl_o.imm_sext = 1'b1;
      end
      OpLi: begin
        // LI writes the rs field register with the zero-extended 8-bit immediate
        ctrl_o.regwr  = 1'b1;
        ctrl_o.regdst = RegDstRs;
        ctrl_o.immsel = Imm8;
        ctrl_o.alu_op = AluPassImm;
      end
      OpLd: begin
        ctrl_o.regwr    = 1'b1;
        ctrl_o.memen    = 1'b1;
        ctrl_o.regdst   = RegDstRt;
        ctrl_o.imm_sext = 1'b1;
      end
      OpSt: begin
        ctrl_o.memen    = 1'b1;
        ctrl_o.memwr    = 1'b1;
        ctrl_o.imm_sext = 1'b1;
      end
      OpBeq: begin
        ctrl_o.is_branch = 1'b1;
        ctrl_o.imm_sext  = 1'b1;
        ctrl_o.alu_op    = AluCmp;
      end
      OpJal: begin
        ctrl_o.regwr    = 1'b1;
        ctrl_o.regdst   = RegDstLink;
        ctrl_o.immsel   = Imm11;
        ctrl_o.imm_sext = 1'b1;
        ctrl_o.is_jump  = 1'b1;
      end
      OpJmp: begin
        ctrl_o.immsel   = Imm11;
        ctrl_o.imm_sext = 1'b1;
        ctrl_o.is_jump  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register file and ID/EX register.
// Optional feature: define RF_BYPASS_EN to forward the write-back port to same-cycle reads.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ifid_valid/instr/pc_inc     instruction from fetch; ifid_ready = accepted this cycle
//   wb_en/wb_sel/wb_data        register-file write port
//   ex_stall                    hold ID/EX
//   flush                       kill the presented instruction and ID/EX, leave HALTED
//   idex_*                      registered ID/EX fields
//   halted                      a HALT has entered ID/EX; decode frozen until flush/rst
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned             DATA_W = 16,
  parameter int unsigned             NREG   = 8,
  parameter logic [DATA_W-1:0]       RST_PC = '0,
  localparam int unsigned            SEL_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifid_valid,
  input  logic [15:0]       ifid_instr,
  input  logic [DATA_W-1:0] ifid_pc_inc,
  output logic              ifid_ready,
  input  logic              wb_en,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              idex_valid,
  output logic [15:0]       idex_instr,
  output logic [DATA_W-1:0] idex_pc_inc,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [SEL_W-1:0]  idex_wsel,
  output logic              idex_regwr,
  output logic              idex_memen,
  output logic              idex_memwr,
  output ctrl_t             idex_ctrl,
  output logic              halted
);

  // Instruction fields; 3-bit register fields are resized to the select width.
  logic [4:0]       opcode;
  logic [SEL_W-1:0] rs_sel, rt_sel, rd_sel;
  assign opcode = ifid_instr[15:11];
  assign rs_sel = SEL_W'(ifid_instr[10:8]);
  assign rt_sel = SEL_W'(ifid_instr[7:5]);
  assign rd_sel = SEL_W'(ifid_instr[4:2]);

  ctrl_t ctrl;
  decode_ctrl u_decode_ctrl (
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  // Register file: two read ports, one write port.
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rs_data, rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_sel] <= wb_data;
    end
  end

`ifdef RF_BYPASS_EN
  assign rs_data = (wb_en && (wb_sel == rs_sel)) ? wb_data : rf_q[rs_sel];
  assign rt_data = (wb_en && (wb_sel == rt_sel)) ? wb_data : rf_q[rt_sel];
`else
  assign rs_data = rf_q[rs_sel];
  assign rt_data = rf_q[rt_sel];
`endif

  // Immediate extension.
  logic [DATA_W-1:0] imm;
  always_comb begin
    case (ctrl.immsel)
      Imm8:    imm = {{(DATA_W-8){ctrl.imm_sext & ifid_instr[7]}}, ifid_instr[7:0]};
      Imm11:   imm = {{(DATA_W-11){ctrl.imm_sext & ifid_instr[10]}}, ifid_instr[10:0]};
      default: imm = {{(DATA_W-5){ctrl.imm_sext & ifid_instr[4]}}, ifid_instr[4:0]};
    endcase
  end

  // Write-register select.
  logic [SEL_W-1:0] wsel;
  always_comb begin
    case (ctrl.regdst)
      RegDstRt:   wsel = rt_sel;
      RegDstRs:   wsel = rs_sel;
      RegDstLink: wsel = SEL_W'(NREG - 1);
      default:    wsel = rd_sel;
    endcase
  end

  // ID/EX registers.
  logic              valid_q, valid_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] pc_inc_q, pc_inc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [SEL_W-1:0]  wsel_q, wsel_d;
  logic              regwr_q, regwr_d;
  logic              memen_q, memen_d;
  logic              memwr_q, memwr_d;
  ctrl_t             ctrl_q, ctrl_d;

  // Load in EX whose destination matches either source field, used or not.
  logic load_use;
  assign load_use = valid_q && memen_q && !memwr_q &&
                    ((wsel_q == rs_sel) || (wsel_q == rt_sel));

  // Presented instruction enters ID/EX; flush kills it even when ready is high.
  logic accept;
  assign accept = ifid_valid && ifid_ready && !flush;

  // FSM: state register / next state / outputs.
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else if ((state_q == StRun) && accept && ctrl.is_halt) begin
      state_d = StHalted;
    end
  end

  always_comb begin
    ifid_ready = !ex_stall && !load_use && (state_q == StRun);
    halted     = (state_q == StHalted);
  end

  // ID/EX next state: flush > stall (hold) > accept > bubble.
  // A bubble clears only the valid/side-effect bits; data fields keep their values.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_inc_d  = pc_inc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    wsel_d    = wsel_q;
    regwr_d   = regwr_q;
    memen_d   = memen_q;
    memwr_d   = memwr_q;
    ctrl_d    = ctrl_q;
    if (!flush && ex_stall) begin
      // hold
    end else if (accept) begin
      valid_d   = 1'b1;
      instr_d   = ifid_instr;
      pc_inc_d  = ifid_pc_inc;
      rs_data_d = rs_data;
      rt_data_d = rt_data;
      imm_d     = imm;
      wsel_d    = wsel;
      regwr_d   = ctrl.regwr;
      memen_d   = ctrl.memen;
      memwr_d   = ctrl.memwr;
      ctrl_d    = ctrl;
    end else begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      memen_d = 1'b0;
      memwr_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_inc_q  <= RST_PC;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      wsel_q    <= '0;
      regwr_q   <= 1'b0;
      memen_q   <= 1'b0;
      memwr_q   <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_inc_q  <= pc_inc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      wsel_q    <= wsel_d;
      regwr_q   <= regwr_d;
      memen_q   <= memen_d;
      memwr_q   <= memwr_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign idex_valid   = valid_q;
  assign idex_instr   = instr_q;
  assign idex_pc_inc  = pc_inc_q;
  assign idex_rs_data = rs_data_q;
  assign idex_rt_data = rt_data_q;
  assign idex_imm     = imm_q;
  assign idex_wsel    = wsel_q;
  assign idex_regwr   = regwr_q;
  assign idex_memen   = memen_q;
  assign idex_memwr   = memwr_q;
  assign idex_ctrl    = ctrl_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_pipe;
  import decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT (DATA_W=16, NREG=8)
  logic        rst, ifid_valid, ifid_ready, wb_en, ex_stall, flush, halted;
  logic [15:0] ifid_instr, ifid_pc_inc, wb_data;
  logic [2:0]  wb_sel, idex_wsel;
  logic        idex_valid, idex_regwr, idex_memen, idex_memwr;
  logic [15:0] idex_instr, idex_pc_inc, idex_rs_data, idex_rt_data, idex_imm;
  ctrl_t       idex_ctrl;

  decode_pipe dut (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc_inc(ifid_pc_inc), .ifid_ready(ifid_ready), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .idex_valid(idex_valid),
    .idex_instr(idex_instr), .idex_pc_inc(idex_pc_inc), .idex_rs_data(idex_rs_data),
    .idex_rt_data(idex_rt_data), .idex_imm(idex_imm), .idex_wsel(idex_wsel),
    .idex_regwr(idex_regwr), .idex_memen(idex_memen), .idex_memwr(idex_memwr),
    .idex_ctrl(idex_ctrl), .halted(halted)
  );

  // Wide DUT (DATA_W=32, NREG=16)
  logic        w_rst, w_valid, w_ready, w_wb_en, w_stall, w_flush, w_halted;
  logic [15:0] w_instr, w_idex_instr;
  logic [31:0] w_pc, w_wb_data, w_idex_pc, w_rs, w_rt, w_imm;
  logic [3:0]  w_wb_sel, w_wsel;
  logic        w_idex_valid, w_regwr, w_memen, w_memwr;
  ctrl_t       w_ctrl;

  decode_pipe #(.DATA_W(32), .NREG(16)) dut_w (
    .clk(clk), .rst(w_rst), .ifid_valid(w_valid), .ifid_instr(w_instr),
    .ifid_pc_inc(w_pc), .ifid_ready(w_ready), .wb_en(w_wb_en), .wb_sel(w_wb_sel),
    .wb_data(w_wb_data), .ex_stall(w_stall), .flush(w_flush), .idex_valid(w_idex_valid),
    .idex_instr(w_idex_instr), .idex_pc_inc(w_idex_pc), .idex_rs_data(w_rs),
    .idex_rt_data(w_rt), .idex_imm(w_imm), .idex_wsel(w_wsel),
    .idex_regwr(w_regwr), .idex_memen(w_memen), .idex_memwr(w_memwr),
    .idex_ctrl(w_ctrl), .halted(w_halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int lo);
    logic [15:0] r;
    r = {op[4:0], rs[2:0], rt[2:0], lo[4:0]};
    return r;
  endfunction

  function automatic int sx(input int v, input int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  // Reference decode from the instruction-set rules.
  function automatic void ref_decode(input logic [15:0] ins, output logic rw, output logic me,
                                     output logic mw, output logic [2:0] dst,
                                     output logic [15:0] imm);
    int op, rs, rt, rd, v5, v11;
    op  = int'(ins[15:11]);
    rs  = int'(ins[10:8]);
    rt  = int'(ins[7:5]);
    rd  = int'(ins[4:2]);
    v5  = int'(ins[4:0]);
    v11 = int'(ins[10:0]);
    rw = 0; me = 0; mw = 0; dst = 3'(rd); imm = 16'(v5);
    case (op)
      1, 2, 3, 4: rw = 1;
      5:  begin rw = 1; dst = 3'(rt); imm = 16'(sx(v5, 5)); end
      6:  begin rw = 1; dst = 3'(rs); imm = 16'(int'(ins[7:0])); end
      8:  begin rw = 1; me = 1; dst = 3'(rt); imm = 16'(sx(v5, 5)); end
      9:  begin me = 1; mw = 1; imm = 16'(sx(v5, 5)); end
      10: imm = 16'(sx(v5, 5));
      12: begin rw = 1; dst = 3'd7; imm = 16'(sx(v11, 11)); end
      13: imm = 16'(sx(v11, 11));
      default: ;
    endcase
  endfunction

  // Model state: what ID/EX should hold, halted flag, register contents.
  logic        e_valid = 0, e_regwr = 0, e_memen = 0, e_memwr = 0, e_halted = 0;
  logic [15:0] e_instr = 0, e_pc = 0, e_rs = 0, e_rt = 0, e_imm = 0;
  logic [2:0]  e_wsel = 0;
  logic [15:0] m_rf [8];

  function automatic logic [15:0] rd_port(input int sel);
`ifdef RF_BYPASS_EN
    if (wb_en && int'(wb_sel) == sel) return wb_data;
`endif
    return m_rf[sel];
  endfunction

  // One clock with the inputs currently driven; checks ready before and ID/EX after.
  task automatic tick();
    logic lu, rdy, rw, me, mw;
    logic [2:0] dst;
    logic [15:0] imm;
    int rs, rt;
    #1;
    rs  = int'(ifid_instr[10:8]);
    rt  = int'(ifid_instr[7:5]);
    lu  = e_valid && e_memen && !e_memwr && (int'(e_wsel) == rs || int'(e_wsel) == rt);
    rdy = !ex_stall && !lu && !e_halted;
    if (!rst) check_eq("ready", ifid_ready, rdy);
    if (rst) begin
      e_valid = 0; e_regwr = 0; e_memen = 0; e_memwr = 0; e_halted = 0;
      e_instr = 0; e_pc = 0; e_rs = 0; e_rt = 0; e_imm = 0; e_wsel = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
    end else begin
      if (flush) begin
        e_valid = 0; e_regwr = 0; e_memen = 0; e_memwr = 0; e_halted = 0;
      end else if (ex_stall) begin
        // ID/EX holds
      end else if (ifid_valid && rdy) begin
        ref_decode(ifid_instr, rw, me, mw, dst, imm);
        e_valid = 1; e_regwr = rw; e_memen = me; e_memwr = mw; e_wsel = dst; e_imm = imm;
        e_instr = ifid_instr; e_pc = ifid_pc_inc;
        e_rs = rd_port(rs); e_rt = rd_port(rt);
        if (ifid_instr[15:11] == 5'd0) e_halted = 1;
      end else begin
        e_valid = 0; e_regwr = 0; e_memen = 0; e_memwr = 0;
      end
      if (wb_en) m_rf[wb_sel] = wb_data;
    end
    @(posedge clk);
    #1;
    check_eq("valid", idex_valid, e_valid);
    check_eq("regwr", idex_regwr, e_regwr);
    check_eq("memen", idex_memen, e_memen);
    check_eq("memwr", idex_memwr, e_memwr);
    check_eq("halted", halted, e_halted);
    if (e_valid) begin
      check_eq("instr", idex_instr, e_instr);
      check_eq("pc_inc", idex_pc_inc, e_pc);
      check_eq("rs_data", idex_rs_data, e_rs);
      check_eq("rt_data", idex_rt_data, e_rt);
      check_eq("imm", idex_imm, e_imm);
      check_eq("wsel", idex_wsel, e_wsel);
    end
  endtask

  task automatic idle();
    rst = 0; ifid_valid = 0; ifid_instr = 0; ifid_pc_inc = 0; wb_en = 0; wb_sel = 0;
    wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  localparam int OpList [12] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12, 13};

  initial begin
    logic [15:0] exp_byp;
    logic [15:0] add_i;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    w_rst = 1; w_valid = 0; w_instr = 0; w_pc = 0; w_wb_en = 0; w_wb_sel = 0;
    w_wb_data = 0; w_stall = 0; w_flush = 0;

    // Reset
    idle(); rst = 1; tick(); rst = 0;
    check_eq("rst_valid", idex_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pc", idex_pc_inc, 0);
    #1 check_eq("rst_ready", ifid_ready, 1);
    for (int i = 0; i < 8; i++) begin
      ifid_valid = 1; ifid_instr = mk(1, i, 7 - i, 0); tick();
      check_eq("rst_rf_rs", idex_rs_data, 0);
      check_eq("rst_rf_rt", idex_rt_data, 0);
    end

    // Load-use: LD r3 then ADD r1,r3,r2
    ifid_instr = mk(8, 1, 3, 0); tick();
    add_i = mk(1, 3, 2, 1 << 2); ifid_instr = add_i;
    #1 check_eq("lu_ready_low", ifid_ready, 0);
    tick();
    check_eq("lu_bubble", idex_valid, 0);
    #1 check_eq("lu_ready_back", ifid_ready, 1);
    tick();
    check_eq("lu_issue_valid", idex_valid, 1);
    check_eq("lu_issue_instr", idex_instr, add_i);

    // Write-back bypass on r2
    idle(); rst = 1; tick(); rst = 0;
    wb_en = 1; wb_sel = 2; wb_data = 16'hBEEF; ifid_valid = 1; ifid_instr = mk(1, 2, 0, 0);
    tick();
`ifdef RF_BYPASS_EN
    exp_byp = 16'hBEEF;
`else
    exp_byp = 16'h0000;
`endif
    check_eq("bypass_rs", idex_rs_data, exp_byp);
    wb_en = 0; tick();
    check_eq("after_wb_rs", idex_rs_data, 16'hBEEF);

    // Stall holds; stall+flush discards
    add_i = mk(1, 2, 1, 3 << 2); ifid_instr = add_i; tick();
    ex_stall = 1; ifid_instr = mk(2, 1, 1, 0); tick();
    check_eq("stall_hold_instr", idex_instr, add_i);
    check_eq("stall_hold_valid", idex_valid, 1);
    flush = 1; tick();
    check_eq("stall_flush_valid", idex_valid, 0);
    ex_stall = 0; flush = 0;

    // HALT freezes decode for as long as no flush arrives
    ifid_instr = mk(0, 0, 0, 0); tick();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_in_idex", idex_valid, 1);
    ifid_instr = mk(1, 1, 2, 0);
    for (int i = 0; i < 10; i++) begin
      #1 check_eq("halt_ready_low", ifid_ready, 0);
      tick();
      check_eq("halt_bubble", idex_valid, 0);
    end
    flush = 1; tick(); flush = 0;
    check_eq("halt_flush_run", halted, 0);
    #1 check_eq("halt_flush_ready", ifid_ready, 1);
    // HALT arriving with flush is killed
    ifid_instr = mk(0, 0, 0, 0); flush = 1; tick(); flush = 0;
    check_eq("halt_flush_same", halted, 0);
    // Reset overrides while halted and stalled
    tick();
    check_eq("halt_again", halted, 1);
    rst = 1; ex_stall = 1; flush = 0; tick(); rst = 0; ex_stall = 0;
    check_eq("rst_in_halt", halted, 0);
    check_eq("rst_in_halt_valid", idex_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      ifid_valid  = ($urandom_range(0, 3) != 0);
      ifid_instr  = {16'($urandom)};
      if ($urandom_range(0, 15) == 0) ifid_instr[15:11] = 5'd0;
      else ifid_instr[15:11] = 5'(OpList[$urandom_range(1, 11)]);
      ifid_pc_inc = 16'($urandom);
      ex_stall    = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      wb_en       = ($urandom_range(0, 1) == 0);
      wb_sel      = 3'($urandom);
      wb_data     = 16'($urandom);
      tick();
    end
    idle();

    // Wide configuration: 32-bit data, 16 registers
    @(posedge clk); #1;
    w_rst = 0; w_wb_en = 1; w_wb_sel = 4'd15; w_wb_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    w_wb_sel = 4'd7; w_wb_data = 32'h1234_5678;
    @(posedge clk); #1;
    w_wb_sel = 4'd3; w_wb_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    w_wb_en = 0; w_valid = 1; w_instr = mk(1, 3, 7, 0);
    @(posedge clk); #1;
    check_eq("w32_rs_data", w_rs, 32'hDEAD_BEEF);
    check_eq("w32_rt_no_alias_r15", w_rt, 32'h1234_5678);
    // r15 is only reachable as the link destination from a 3-bit field
    w_instr = mk(12, 4, 0, 0); w_pc = 32'h0000_1002;
    @(posedge clk); #1;
    check_eq("w32_link_wsel", 32'(w_wsel), 32'd15);
    check_eq("w32_imm11_sext", w_imm, 32'hFFFF_FC00);
    check_eq("w32_pc_inc", w_idex_pc, 32'h0000_1002);
    w_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
